// File: rtl/wallace_reduce_pkg.sv
// Shared types and constants for the iterative Wallace partial-product reducer.
package wallace_reduce_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int CMP_IN  = 5;
    localparam int CMP_OUT = 3;

    // Width of a row counter able to hold 0..num_pp
    function automatic int cnt_w(input int num_pp);
        return $clog2(num_pp + 1);
    endfunction

endpackage

// File: rtl/wallace_reduce_sequencer_compressor_row_5to3.sv
// One row of per-bit 4:2 cells: x1 is the carry-in lane, x2..x5 the data lanes.
module compressor_row_5to3 #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] x2,
    input  logic [WIDTH-1:0] x3,
    input  logic [WIDTH-1:0] x4,
    input  logic [WIDTH-1:0] x5,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3
);

    logic [WIDTH-1:0] caryout;
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] cary;
    logic [WIDTH-1:0] sum;

    assign caryout = (x2 & x3) | (x2 & x4) | (x3 & x4);
    assign s1      = x2 ^ x3 ^ x4;
    assign cary    = (s1 & x5) | (s1 & x1) | (x5 & x1);
    assign sum     = s1 ^ x5 ^ x1;

    // Weight-2 outputs move up one bit; the MSB carry falls off (mod 2^WIDTH)
    assign out1 = sum;
    assign out2 = cary << 1;
    assign out3 = caryout << 1;

endmodule

// File: rtl/wallace_reduce_sequencer.sv
// Iterative reducer: one shared 5:3 compressor row folds the row buffer down to a sum/carry pair.
module wallace_reduce_sequencer
    import wallace_reduce_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int NUM_PP = 17
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [$clog2(NUM_PP+1)-1:0] pp_cnt_i,
    input  logic [WIDTH*NUM_PP-1:0]     pp_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [WIDTH-1:0]            sum_o,
    output logic [WIDTH-1:0]            carry_o,
    output logic                        busy_o
);

    localparam int CNT_W = cnt_w(NUM_PP);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] load_cnt;
    logic [CNT_W-1:0] step_cnt;
    logic [WIDTH-1:0] row_q    [NUM_PP];
    logic [WIDTH-1:0] row_load [NUM_PP];
    logic [WIDTH-1:0] row_step [NUM_PP];
    // Buffer padded with zero rows so head reads never fall off the end
    logic [WIDTH-1:0] ext      [NUM_PP+CMP_IN];
    logic [WIDTH-1:0] x1, x2, x3, x4, x5;
    logic [WIDTH-1:0] out1, out2, out3;
    logic             accept;
    int               live_n;
    int               rem_n;

    assign accept   = (state_q == IDLE) && in_valid_i && !flush_i;
    assign load_cnt = (pp_cnt_i > CNT_W'(NUM_PP)) ? CNT_W'(NUM_PP) : pp_cnt_i;
    assign step_cnt = (cnt_q >= CNT_W'(5)) ? cnt_q - CNT_W'(2) : cnt_q - CNT_W'(1);

    always_comb begin
        for (int i = 0; i < NUM_PP; i++) begin
            ext[i] = row_q[i];
        end
        for (int i = NUM_PP; i < NUM_PP + CMP_IN; i++) begin
            ext[i] = '0;
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_PP; r++) begin
            row_load[r] = (CNT_W'(r) < load_cnt) ? pp_i[r*WIDTH +: WIDTH] : '0;
        end
    end

    // Three live rows ride x2..x4 so the x1/x5 carry path is provably zero
    always_comb begin
        x1 = '0;
        x2 = '0;
        x3 = '0;
        x4 = '0;
        x5 = '0;
        if (cnt_q >= CNT_W'(5)) begin
            x1 = ext[0];
            x2 = ext[1];
            x3 = ext[2];
            x4 = ext[3];
            x5 = ext[4];
        end else if (cnt_q == CNT_W'(4)) begin
            x1 = ext[0];
            x2 = ext[1];
            x3 = ext[2];
            x4 = ext[3];
        end else if (cnt_q == CNT_W'(3)) begin
            x2 = ext[0];
            x3 = ext[1];
            x4 = ext[2];
        end
    end

    compressor_row_5to3 #(
        .WIDTH(WIDTH)
    ) u_cmp (
        .x1  (x1),
        .x2  (x2),
        .x3  (x3),
        .x4  (x4),
        .x5  (x5),
        .out1(out1),
        .out2(out2),
        .out3(out3)
    );

    // Only a 5-row step leaves rows behind, so the head always shifts by CMP_IN
    always_comb begin
        live_n = int'(cnt_q);
        rem_n  = (live_n >= CMP_IN) ? live_n - CMP_IN : 0;
        for (int i = 0; i < NUM_PP; i++) begin
            row_step[i] = '0;
            if (i < rem_n) begin
                row_step[i] = ext[i+CMP_IN];
            end else if (i == rem_n) begin
                row_step[i] = out1;
            end else if (i == rem_n + 1) begin
                row_step[i] = (live_n == 3) ? out3 : out2;
            end else if ((i == rem_n + CMP_OUT - 1) && (live_n != 3)) begin
                row_step[i] = out3;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        state_d = (load_cnt <= CNT_W'(2)) ? DONE : REDUCE;
                    end
                end
                REDUCE: begin
                    if (step_cnt <= CNT_W'(2)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            for (int i = 0; i < NUM_PP; i++) begin
                row_q[i] <= '0;
            end
        end else if (flush_i) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= load_cnt;
            for (int i = 0; i < NUM_PP; i++) begin
                row_q[i] <= row_load[i];
            end
        end else if (state_q == REDUCE) begin
            cnt_q <= step_cnt;
            for (int i = 0; i < NUM_PP; i++) begin
                row_q[i] <= row_step[i];
            end
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign sum_o       = (state_q == DONE) ? row_q[0] : '0;
    assign carry_o     = (state_q == DONE) ? row_q[1] : '0;

endmodule

// File: tb/tb_wallace_reduce_sequencer.sv
// Self-checking bench: vector table, hand-written corner sequences and a randomized scoreboard run.
module tb_wallace_reduce_sequencer;

    localparam int W   = 64;
    localparam int NP  = 17;
    localparam int CW  = $clog2(NP + 1);
    localparam int PPW = W * NP;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] pp_cnt = '0;
    logic [PPW-1:0] pp = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  sum;
    logic [W-1:0]  carry;
    logic          busy;

    int errors = 0;
    int checks = 0;

    wallace_reduce_sequencer #(.WIDTH(W), .NUM_PP(NP)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .flush_i    (flush),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .pp_cnt_i   (pp_cnt),
        .pp_i       (pp),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .sum_o      (sum),
        .carry_o    (carry),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cnt;
        logic [63:0] r0;
        logic [63:0] r1;
        logic [63:0] rest;
        logic [63:0] exp_total;
        int          exp_lat;
        bit          exact;
        logic [63:0] exp_sum;
        logic [63:0] exp_carry;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: rows below min(cnt,NP) added with plain modular arithmetic
    function automatic logic [63:0] model_sum(input int cnt, input logic [PPW-1:0] rows);
        logic [63:0] acc = '0;
        int n = (cnt > NP) ? NP : cnt;
        for (int r = 0; r < n; r++) acc += rows[r*W +: W];
        return acc;
    endfunction

    // Reference latency: each step removes two rows while five or more remain, otherwise one
    function automatic int model_lat(input int cnt);
        int n = (cnt > NP) ? NP : cnt;
        int steps = 0;
        while (n > 2) begin
            n = (n >= 5) ? n - 2 : n - 1;
            steps++;
        end
        return 1 + steps;
    endfunction

    function automatic logic [PPW-1:0] random_rows();
        logic [PPW-1:0] v;
        for (int r = 0; r < NP; r++) v[r*W +: W] = {$urandom(), $urandom()};
        return v;
    endfunction

    // Offer one op, wait for the result, hold it rdy_delay cycles, then consume it
    task automatic do_op(input string tag, input int cnt, input logic [PPW-1:0] rows,
                         input int rdy_delay, input logic [63:0] exp_total, input int exp_lat,
                         input bit exact, input logic [63:0] es, input logic [63:0] ec);
        int          lat = 0;
        bit          got = 1'b0;
        bit          ready_bad = 1'b0;
        bit          hold_bad = 1'b0;
        logic [63:0] s, c;
        in_valid = 1'b1;
        pp_cnt   = CW'(cnt);
        pp       = rows;
        for (int i = 0; i < 64 && !got; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat++;
            if (in_ready !== 1'b0) ready_bad = 1'b1;
            if (out_valid === 1'b1) got = 1'b1;
        end
        if (!got) begin
            chk({tag, " timeout"}, 64'd0, 64'd1);
            return;
        end
        s = sum;
        c = carry;
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " sum+carry"}, s + c, exp_total);
        chk({tag, " in_ready low while busy"}, 64'(ready_bad), 64'd0);
        if (exact) begin
            chk({tag, " sum"}, s, es);
            chk({tag, " carry"}, c, ec);
        end
        for (int i = 0; i < rdy_delay; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || sum !== s || carry !== c) hold_bad = 1'b1;
        end
        if (rdy_delay > 0) chk({tag, " hold stable"}, 64'(hold_bad), 64'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " idle after consume"}, {62'd0, out_valid, in_ready}, 64'd1);
    endtask

    function automatic logic [PPW-1:0] build_rows(input vec_t v);
        logic [PPW-1:0] rows;
        for (int r = 0; r < NP; r++) begin
            if (r >= v.cnt)  rows[r*W +: W] = {$urandom(), $urandom()};
            else if (r == 0) rows[r*W +: W] = v.r0;
            else if (r == 1) rows[r*W +: W] = v.r1;
            else             rows[r*W +: W] = v.rest;
        end
        return rows;
    endfunction

    initial begin
        vec_t           vecs [9];
        logic [PPW-1:0] rows;
        logic [63:0]    s, c;
        bit             bad;
        int             cnt;

        vecs[0] = '{17, 64'h1, 64'h1, 64'h1, 64'd17, 9, 1'b0, 64'd0, 64'd0};
        vecs[1] = '{4, '1, '1, '1, 64'hFFFF_FFFF_FFFF_FFFC, 3, 1'b0, 64'd0, 64'd0};
        vecs[2] = '{2, 64'h1234, 64'h00FF, 64'h0, 64'h1333, 1, 1'b1, 64'h1234, 64'h00FF};
        vecs[3] = '{1, 64'h55, 64'h0, 64'h0, 64'h55, 1, 1'b1, 64'h55, 64'h0};
        vecs[4] = '{0, 64'h0, 64'h0, 64'h0, 64'h0, 1, 1'b1, 64'h0, 64'h0};
        vecs[5] = '{31, 64'h1, 64'h1, 64'h1, 64'd17, 9, 1'b0, 64'd0, 64'd0};
        vecs[6] = '{5, 64'h1, 64'h2, 64'h4, 64'd15, 3, 1'b0, 64'd0, 64'd0};
        vecs[7] = '{3, 64'h7, 64'h9, 64'hA, 64'h1A, 2, 1'b0, 64'd0, 64'd0};
        vecs[8] = '{17, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                    64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 9, 1'b0, 64'd0, 64'd0};

        #12;
        chk("reset outputs", {60'd0, in_ready, out_valid, busy, 1'b0}, 64'h8);
        chk("reset sum", sum, 64'd0);
        chk("reset carry", carry, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 9; v++) begin
            rows = build_rows(vecs[v]);
            do_op($sformatf("vec%0d", v), vecs[v].cnt, rows, 0, vecs[v].exp_total,
                  vecs[v].exp_lat, vecs[v].exact, vecs[v].exp_sum, vecs[v].exp_carry);
        end

        // Backpressure: result held five cycles while a new offer is ignored
        rows = random_rows();
        in_valid = 1'b1; pp_cnt = CW'(5); pp = rows;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 16 && out_valid !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        chk("bp valid", 64'(out_valid), 64'd1);
        s = sum; c = carry;
        chk("bp sum+carry", s + c, model_sum(5, rows));
        in_valid = 1'b1; pp_cnt = CW'(6); pp = random_rows();
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== s || carry !== c) bad = 1'b1;
        end
        chk("bp hold and ignore input", 64'(bad), 64'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp release to idle", {62'd0, in_ready, out_valid}, 64'h2);
        rows = pp;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp back-to-back accepted", 64'(busy), 64'd1);
        for (int i = 0; i < 16 && out_valid !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        chk("bp second result", sum + carry, model_sum(6, rows));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Flush during the third REDUCE cycle, then again in IDLE against an offer
        in_valid = 1'b1; pp_cnt = CW'(17); pp = random_rows();
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        chk("flush to idle", {61'd0, busy, out_valid, in_ready}, 64'h1);
        in_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush blocks offer", 64'(busy), 64'd0);
        bad = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) bad = 1'b1;
        end
        chk("flush no result", 64'(bad), 64'd0);
        rows = build_rows(vecs[0]);
        do_op("post-flush", 17, rows, 1, 64'd17, 9, 1'b0, 64'd0, 64'd0);

        // Asynchronous reset in the middle of a reduction
        in_valid = 1'b1; pp_cnt = CW'(17); pp = random_rows();
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("async rst flags", {61'd0, in_ready, out_valid, busy}, 64'h4);
        chk("async rst sum", sum, 64'd0);
        chk("async rst carry", carry, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        rows = random_rows();
        do_op("post-reset", 9, rows, 0, model_sum(9, rows), model_lat(9), 1'b0, 64'd0, 64'd0);

        // Randomized ops against the scoreboard
        for (int k = 0; k < 3000; k++) begin
            cnt  = $urandom_range(0, 17);
            rows = random_rows();
            do_op($sformatf("rnd%0d n=%0d", k, cnt), cnt, rows, $urandom_range(0, 2),
                  model_sum(cnt, rows), model_lat(cnt), 1'b0, 64'd0, 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
